// File: rtl/dcache_write_buffer.sv
// Line-granular write buffer between the D-cache and slow data memory.
// Queues writebacks, drains them in the background, forwards buffered lines on read hits.
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic                    c_read,
  input  logic                    c_write,
  input  logic [ADDR_W-1:0]       c_addr,
  input  logic [LINE_W-1:0]       c_wdata,
  output logic [LINE_W-1:0]       c_rdata,
  output logic                    c_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_W-1:0]       mem_wdata,
  input  logic [LINE_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    wb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] c_rdata_q, c_rdata_d;
  logic              c_ready_q, c_ready_d;

  logic              live, wr_live, rd_live, hit, coalesce, push, pop, rd_hit, rd_miss;
  logic [PTR_W-1:0]  hit_idx;

  // Scan oldest to youngest so the last match wins: the newest copy of a line.
  always_comb begin : match_scan
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = head_q;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == c_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign live     = (c_read | c_write) & ~c_ready_q;
  assign wr_live  = live & c_write;
  assign rd_live  = live & c_read & ~c_write;
  // The head being written to memory must not change under the transfer.
  assign coalesce = wr_live & hit & ~((state_q == ST_WRITE) & (hit_idx == head_q));
  assign push     = wr_live & ~coalesce & (count_q < CNT_W'(DEPTH));
  assign pop      = (state_q == ST_WRITE) & mem_ready;
  assign rd_hit   = rd_live & hit;
  assign rd_miss  = rd_live & ~hit;

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    c_rdata_d  = c_rdata_q;
    c_ready_d  = coalesce | push | rd_hit;
    head_d     = head_q + PTR_W'(pop);
    tail_d     = tail_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    valid_d    = valid_q;
    if (pop)    valid_d[head_q] = 1'b0;
    if (push)   valid_d[tail_q] = 1'b1;
    if (rd_hit) c_rdata_d = data_q[hit_idx];
    case (state_q)
      ST_IDLE: begin
        // Read misses go ahead of pending drains.
        if (rd_miss) begin
          state_d    = ST_READ;
          mem_addr_d = c_addr;
        end else if (count_q != '0) begin
          state_d    = ST_WRITE;
          mem_addr_d = addr_q[head_q];
        end
      end
      ST_WRITE: begin
        if (mem_ready) state_d = ST_IDLE;
      end
      ST_READ: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          c_rdata_d = mem_rdata;
          c_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      c_rdata_q  <= '0;
      c_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      c_rdata_q  <= c_rdata_d;
      c_ready_q  <= c_ready_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= c_addr;
      data_q[tail_q] <= c_wdata;
    end else if (coalesce) begin
      data_q[hit_idx] <= c_wdata;
    end
  end

  assign mem_write = (state_q == ST_WRITE);
  assign mem_read  = (state_q == ST_READ);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_write ? data_q[head_q] : '0;
  assign c_rdata   = c_rdata_q;
  assign c_ready   = c_ready_q;
  assign wb_count  = count_q;
  assign wb_empty  = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: reset, drain, forwarding, coalescing,
// full back-pressure, read priority and simultaneous push/pop.
module tb_dcache_write_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset = 1'b0;
  logic              c_read = 1'b0, c_write = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic [LINE_W-1:0] c_wdata = '0;
  logic [LINE_W-1:0] c_rdata;
  logic              c_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic [2:0]        wb_count;
  logic              wb_empty;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_read_cycles = 0;

  dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .proc_reset(proc_reset), .c_read(c_read), .c_write(c_write),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_read) mem_read_cycles <= mem_read_cycles + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cache write handshake; steps = edges from request to visible c_ready.
  task automatic cache_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                             output int steps);
    c_write = 1'b1; c_addr = a; c_wdata = d; steps = 0;
    do begin step(); steps++; end while (c_ready !== 1'b1 && steps < 20);
    c_write = 1'b0;
    step();
  endtask

  task automatic cache_read(input logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] d,
                            output int steps);
    c_read = 1'b1; c_addr = a; steps = 0;
    do begin step(); steps++; end while (c_ready !== 1'b1 && steps < 20);
    d = c_rdata;
    c_read = 1'b0;
    step();
  endtask

  // Wait (bounded) for a memory request, capture it, complete it with one mem_ready pulse.
  task automatic mem_complete(output bit ok, output logic [ADDR_W-1:0] a,
                              output logic [LINE_W-1:0] d);
    int n = 0;
    ok = 1'b0; a = '0; d = '0;
    while (!(mem_write || mem_read) && n < 20) begin step(); n++; end
    if (mem_write || mem_read) begin
      ok = 1'b1; a = mem_addr; d = mem_wdata;
      mem_ready = 1'b1; step(); mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    int st;
    proc_reset = 1'b1; step(); step();
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write: got %0b want 0", mem_write); end
    n_cmp++; if (c_ready !== 1'b0) begin n_bad++; $display("FAIL reset_c_ready: got %0b want 0", c_ready); end
    n_cmp++; if (wb_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", wb_count); end
    n_cmp++; if (wb_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %0b want 1", wb_empty); end
    proc_reset = 1'b0; step();
    cache_write(28'h0000005, {4{32'h55555555}}, st);
    n_cmp++; if (mem_write !== 1'b1) begin n_bad++; $display("FAIL reset_pre_write: got %0b want 1", mem_write); end
    proc_reset = 1'b1; step();
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mid_write: got %0b want 0", mem_write); end
    n_cmp++; if (wb_count !== 3'd0) begin n_bad++; $display("FAIL reset_mid_count: got %0d want 0", wb_count); end
    proc_reset = 1'b0; step();
  endtask

  task automatic test_drain();
    int st, held;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    cache_write(28'h0000010, {4{32'h11111111}}, st);
    n_cmp++; if (st != 1) begin n_bad++; $display("FAIL drain_c_ready_lat: got %0d want 1", st); end
    n_cmp++; if (mem_write !== 1'b1 || mem_addr !== 28'h0000010) begin n_bad++;
      $display("FAIL drain_mem_addr: got we=%0b addr=%0h want we=1 addr=10", mem_write, mem_addr); end
    n_cmp++; if (mem_wdata !== {4{32'h11111111}}) begin n_bad++; $display("FAIL drain_wdata: got %0h want 1111..", mem_wdata); end
    held = 0;
    for (int i = 0; i < 4; i++) begin step(); if (mem_write === 1'b1) held++; end
    n_cmp++; if (held != 4) begin n_bad++; $display("FAIL drain_held: got %0d want 4", held); end
    mem_complete(ok, a, d);
    n_cmp++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin n_bad++;
      $display("FAIL drain_done: got count=%0d empty=%0b want 0/1", wb_count, wb_empty); end
  endtask

  task automatic test_forward();
    int st, rd0;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    rd0 = mem_read_cycles;
    cache_write(28'h0000020, {4{32'hD1D1D1D1}}, st);
    cache_read(28'h0000020, d, st);
    n_cmp++; if (st != 1) begin n_bad++; $display("FAIL fwd_latency: got %0d want 1", st); end
    n_cmp++; if (d !== {4{32'hD1D1D1D1}}) begin n_bad++; $display("FAIL fwd_data: got %0h want d1d1..", d); end
    n_cmp++; if (mem_read_cycles != rd0) begin n_bad++; $display("FAIL fwd_no_memread: got %0d want %0d", mem_read_cycles, rd0); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h0000020 || d !== {4{32'hD1D1D1D1}}) begin n_bad++;
      $display("FAIL fwd_drain: got ok=%0b addr=%0h want addr=20", ok, a); end
  endtask

  task automatic test_coalesce();
    int st;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    cache_write(28'h0000030, {4{32'hA0A0A0A0}}, st);
    cache_write(28'h0000031, {4{32'hB1B1B1B1}}, st);
    cache_write(28'h0000031, {4{32'hD2D2D2D2}}, st);
    n_cmp++; if (st != 1 || wb_count !== 3'd2) begin n_bad++;
      $display("FAIL coal_b_count: got steps=%0d count=%0d want 1/2", st, wb_count); end
    cache_read(28'h0000031, d, st);
    n_cmp++; if (d !== {4{32'hD2D2D2D2}}) begin n_bad++; $display("FAIL coal_b_read: got %0h want d2d2..", d); end
    cache_write(28'h0000030, {4{32'hD3D3D3D3}}, st);
    n_cmp++; if (wb_count !== 3'd3) begin n_bad++; $display("FAIL coal_head_alloc: got %0d want 3", wb_count); end
    cache_read(28'h0000030, d, st);
    n_cmp++; if (d !== {4{32'hD3D3D3D3}}) begin n_bad++; $display("FAIL coal_a_read: got %0h want d3d3..", d); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h30 || d !== {4{32'hA0A0A0A0}}) begin n_bad++;
      $display("FAIL coal_drain1: got addr=%0h data=%0h want 30/a0a0..", a, d); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h31 || d !== {4{32'hD2D2D2D2}}) begin n_bad++;
      $display("FAIL coal_drain2: got addr=%0h data=%0h want 31/d2d2..", a, d); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h30 || d !== {4{32'hD3D3D3D3}}) begin n_bad++;
      $display("FAIL coal_drain3: got addr=%0h data=%0h want 30/d3d3..", a, d); end
    n_cmp++; if (wb_count !== 3'd0) begin n_bad++; $display("FAIL coal_final_count: got %0d want 0", wb_count); end
  endtask

  task automatic test_full();
    int st, early;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    for (int i = 0; i < 4; i++) cache_write(28'h50 + ADDR_W'(i), {4{32'hF0 + i}}, st);
    n_cmp++; if (wb_count !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", wb_count); end
    cache_write(28'h52, {4{32'hC2C2C2C2}}, st);
    n_cmp++; if (st != 1 || wb_count !== 3'd4) begin n_bad++;
      $display("FAIL full_coalesce: got steps=%0d count=%0d want 1/4", st, wb_count); end
    c_write = 1'b1; c_addr = 28'h54; c_wdata = {4{32'hF4F4F4F4}};
    early = 0;
    for (int i = 0; i < 3; i++) begin step(); if (c_ready !== 1'b0) early++; end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL full_stall: got %0d ready cycles want 0", early); end
    n_cmp++; if (mem_addr !== 28'h50) begin n_bad++; $display("FAIL full_head_addr: got %0h want 50", mem_addr); end
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    n_cmp++; if (c_ready !== 1'b0 || wb_count !== 3'd3) begin n_bad++;
      $display("FAIL full_pop: got ready=%0b count=%0d want 0/3", c_ready, wb_count); end
    step();
    n_cmp++; if (c_ready !== 1'b1 || wb_count !== 3'd4) begin n_bad++;
      $display("FAIL full_accept: got ready=%0b count=%0d want 1/4", c_ready, wb_count); end
    c_write = 1'b0; step();
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h51) begin n_bad++; $display("FAIL full_drain1: got addr=%0h want 51", a); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h52 || d !== {4{32'hC2C2C2C2}}) begin n_bad++;
      $display("FAIL full_drain2: got addr=%0h data=%0h want 52/c2c2..", a, d); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h53) begin n_bad++; $display("FAIL full_drain3: got addr=%0h want 53", a); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h54 || d !== {4{32'hF4F4F4F4}}) begin n_bad++;
      $display("FAIL full_drain4: got addr=%0h data=%0h want 54/f4f4..", a, d); end
    n_cmp++; if (wb_empty !== 1'b1) begin n_bad++; $display("FAIL full_empty: got %0b want 1", wb_empty); end
  endtask

  task automatic test_read_priority();
    int st;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    cache_write(28'h60, {4{32'hE1E1E1E1}}, st);
    cache_write(28'h61, {4{32'hE2E2E2E2}}, st);
    c_read = 1'b1; c_addr = 28'h40;
    step(); step();
    n_cmp++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || c_ready !== 1'b0) begin n_bad++;
      $display("FAIL prio_wait: got we=%0b re=%0b rdy=%0b want 1/0/0", mem_write, mem_read, c_ready); end
    mem_rdata = {4{32'h4E4E4E4E}};
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    step();
    n_cmp++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h40) begin n_bad++;
      $display("FAIL prio_issue: got re=%0b we=%0b addr=%0h want 1/0/40", mem_read, mem_write, mem_addr); end
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    n_cmp++; if (c_ready !== 1'b1 || c_rdata !== {4{32'h4E4E4E4E}}) begin n_bad++;
      $display("FAIL prio_rdata: got rdy=%0b data=%0h want 1/4e4e..", c_ready, c_rdata); end
    c_read = 1'b0; step();
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h61 || d !== {4{32'hE2E2E2E2}}) begin n_bad++;
      $display("FAIL prio_drain2: got addr=%0h data=%0h want 61/e2e2..", a, d); end
  endtask

  task automatic test_back_to_back();
    int st;
    bit ok;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] d;
    cache_write(28'h70, {4{32'h70707070}}, st);
    cache_write(28'h71, {4{32'h71717171}}, st);
    c_write = 1'b1; c_addr = 28'h72; c_wdata = {4{32'h72727272}};
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    n_cmp++; if (c_ready !== 1'b1 || wb_count !== 3'd2) begin n_bad++;
      $display("FAIL b2b_count: got rdy=%0b count=%0d want 1/2", c_ready, wb_count); end
    c_write = 1'b0; step();
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h71) begin n_bad++; $display("FAIL b2b_drain1: got addr=%0h want 71", a); end
    mem_complete(ok, a, d);
    n_cmp++; if (!ok || a !== 28'h72 || d !== {4{32'h72727272}}) begin n_bad++;
      $display("FAIL b2b_drain2: got addr=%0h data=%0h want 72/7272..", a, d); end
    n_cmp++; if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin n_bad++;
      $display("FAIL b2b_empty: got count=%0d empty=%0b want 0/1", wb_count, wb_empty); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_forward();
    test_coalesce();
    test_full();
    test_read_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
